memory_bram_ctrl: RTL and testbench

- Bus-side controller that sits directly upstream of one port of the dual-port internal-memory BRAM.
- Converts 32-bit byte-selectable bus requests (CPU instruction or data port) into full-word BRAM port accesses.
- Absorbs the BRAM's one-cycle registered-address read latency.
- Performs read-modify-write for partial (byte/halfword) stores and returns a single-cycle ready handshake.

---
 rtl/memory_bram_ctrl.sv | 119 +++++++++++
 tb/tb_memory_bram_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bram_ctrl.sv
// Bus-side controller for one port of the internal-memory BRAM: word reads, full/partial writes (RMW), ready pulse.
// Optional out-of-range address check enabled by defining BRAM_CTRL_ADDR_CHECK_EN.
module memory_bram_ctrl #(
  parameter int addr_size = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          bus_addr,
  input  logic [31:0]          bus_wdata,
  input  logic [3:0]           bus_sel,
  input  logic                 bus_we,
  input  logic                 bus_en,
  output logic [31:0]          bus_rdata,
  output logic                 bus_ready,
  output logic                 bus_error,
  output logic [addr_size-1:0] bram_addr,
  output logic [31:0]          bram_din,
  output logic                 bram_wr,
  input  logic [31:0]          bram_dout
);

  typedef enum logic [1:0] {IDLE, READ, MERGE, ACK} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [addr_size-1:0] addr_q;
  logic [31:0]          wdata_q;
  logic [3:0]           sel_q;
  logic [31:0]          merged;
  logic                 out_of_range;
  logic                 accept;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^{bus_addr[31:addr_size+2], bus_addr[1:0]};
  assign accept = (state == IDLE) && bus_en;

`ifdef BRAM_CTRL_ADDR_CHECK_EN
  logic err_q;

  assign out_of_range = |bus_addr[31:addr_size+2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (accept)
      err_q <= out_of_range;
  end

  assign bus_ready = (state == ACK) && !err_q;
  assign bus_error = (state == ACK) && err_q;
`else
  assign out_of_range = 1'b0;
  assign bus_ready    = (state == ACK);
  assign bus_error    = 1'b0;
`endif

  // Per-lane merge of the latched store data over the word read in the accept cycle.
  always_comb begin
    merged = bram_dout;
    for (int i = 0; i < 4; i++) begin
      if (sel_q[i])
        merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      bus_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= bus_addr[addr_size+1:2];
        wdata_q <= bus_wdata;
        sel_q   <= bus_sel;
      end
      if (state == READ)
        bus_rdata <= bram_dout;
    end
  end

  // The address goes straight to the BRAM in IDLE so its registered read starts in the accept cycle.
  always_comb begin
    state_nxt = state;
    bram_wr   = 1'b0;
    bram_din  = bus_wdata;
    bram_addr = addr_q;
    case (state)
      IDLE: begin
        bram_addr = bus_addr[addr_size+1:2];
        if (bus_en && rst_n) begin
          if (out_of_range)
            state_nxt = ACK;
          else if (!bus_we)
            state_nxt = READ;
          else if (bus_sel == 4'b1111) begin
            bram_wr   = 1'b1;
            state_nxt = ACK;
          end else if (bus_sel == 4'b0000)
            state_nxt = ACK;
          else
            state_nxt = MERGE;
        end
      end
      READ:    state_nxt = ACK;
      MERGE: begin
        bram_din  = merged;
        bram_wr   = 1'b1;
        state_nxt = ACK;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_bram_ctrl.sv
// Scoreboard bench for memory_bram_ctrl: random bus traffic against a word-array reference model.
// Honours BRAM_CTRL_ADDR_CHECK_EN the same way as the design.
module tb_memory_bram_ctrl;

  localparam int ADDR_SIZE = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [31:0]          bus_addr;
  logic [31:0]          bus_wdata;
  logic [3:0]           bus_sel;
  logic                 bus_we;
  logic                 bus_en;
  logic [31:0]          bus_rdata;
  logic                 bus_ready;
  logic                 bus_error;
  logic [ADDR_SIZE-1:0] bram_addr;
  logic [31:0]          bram_din;
  logic                 bram_wr;
  logic [31:0]          bram_dout;

  typedef struct {
    int          exp_cyc;
    bit          is_err;
    logic [31:0] rdata;
    int          wr_base;
    int          exp_wr;
  } sb_item_t;

  sb_item_t    exp_q[$];
  sb_item_t    mon_item;
  logic [31:0] ref_mem [2**ADDR_SIZE];
  logic [31:0] bram_mem [2**ADDR_SIZE];
  logic [31:0] last_rdata = '0;
  int          cyc = 0;
  int          wr_count = 0;
  int          errors = 0;
  int          checks = 0;

  memory_bram_ctrl #(.addr_size(ADDR_SIZE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_sel   (bus_sel),
    .bus_we    (bus_we),
    .bus_en    (bus_en),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .bus_error (bus_error),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .bram_wr   (bram_wr),
    .bram_dout (bram_dout)
  );

  always #5 clk = ~clk;

  // Attached BRAM port: registered address, read-before-write.
  always @(posedge clk) begin
    if (bram_wr)
      bram_mem[bram_addr] <= bram_din;
    bram_dout <= bram_mem[bram_addr];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bram_wr)
      wr_count <= wr_count + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (bus_ready || bus_error)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_handshake: got ready=%b error=%b at cycle %0d expected none", bus_ready, bus_error, cyc);
      end else begin
        mon_item = exp_q.pop_front();
        checkOutput("completion_cycle", cyc, mon_item.exp_cyc);
        checkOutput("bus_ready", {31'd0, bus_ready}, {31'd0, !mon_item.is_err});
        checkOutput("bus_error", {31'd0, bus_error}, {31'd0, mon_item.is_err});
        checkOutput("bus_rdata", bus_rdata, mon_item.rdata);
        checkOutput("bram_writes", wr_count - mon_item.wr_base, mon_item.exp_wr);
      end
    end
  end

  task automatic waitIdle();
    for (int t = 0; t < 20 && exp_q.size() != 0; t++)
      @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshake_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic bit outOfRange(input logic [31:0] addr);
`ifdef BRAM_CTRL_ADDR_CHECK_EN
    return addr[31:ADDR_SIZE+2] != '0;
`else
    return addr[31:ADDR_SIZE+2] != '0 && 1'b0;
`endif
  endfunction

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] sel);
    sb_item_t it;
    int       w;
    int       lat;
    @(negedge clk);
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wdata;
    bus_sel   = sel;
    bus_en    = 1'b1;
    w          = int'(addr[ADDR_SIZE+1:2]);
    it.is_err  = 1'b0;
    it.exp_wr  = 0;
    it.wr_base = wr_count;
    if (outOfRange(addr)) begin
      it.is_err = 1'b1;
      lat       = 1;
    end else if (!we) begin
      last_rdata = ref_mem[w];
      lat        = 2;
    end else if (sel == 4'b0000) begin
      lat = 1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (sel[b])
          ref_mem[w][8*b +: 8] = wdata[8*b +: 8];
      lat       = (sel == 4'b1111) ? 1 : 2;
      it.exp_wr = 1;
    end
    it.exp_cyc = cyc + lat;
    it.rdata   = last_rdata;
    exp_q.push_back(it);
    @(negedge clk);
    bus_en    = 1'b0;
    bus_we    = 1'($urandom);
    bus_addr  = $urandom;
    bus_wdata = $urandom;
    bus_sel   = 4'($urandom);
    waitIdle();
  endtask

  task automatic applyBackToBack();
    sb_item_t it;
    @(negedge clk);
    bus_we = 1'b0;
    bus_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_addr   = 32'(i * 4);
      bus_sel    = 4'($urandom);
      last_rdata = ref_mem[i];
      it.is_err  = 1'b0;
      it.exp_wr  = 0;
      it.wr_base = wr_count;
      it.rdata   = last_rdata;
      it.exp_cyc = cyc + 2;
      exp_q.push_back(it);
      if (i < 2)
        repeat (3) @(negedge clk);
    end
    @(negedge clk);
    bus_en = 1'b0;
    waitIdle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] addr;
    logic [3:0]  sel;
    rst_n     = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_sel   = '0;
    bus_we    = 1'b0;
    bus_en    = 1'b0;
    #3;
    checkOutput("reset_ready", {31'd0, bus_ready}, 32'd0);
    checkOutput("reset_error", {31'd0, bus_error}, 32'd0);
    checkOutput("reset_rdata", bus_rdata, 32'd0);
    checkOutput("reset_bram_wr", {31'd0, bram_wr}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++)
      applyStimulus(1'b1, 32'(i * 4), $urandom, 4'b1111);

    // Reset asserted while the partial write to word 0x05 is in MERGE must abort the commit.
    @(negedge clk);
    bus_we    = 1'b1;
    bus_addr  = 32'h14;
    bus_wdata = $urandom;
    bus_sel   = 4'b0011;
    bus_en    = 1'b1;
    @(negedge clk);
    bus_en = 1'b0;
    checkOutput("merge_bram_wr", {31'd0, bram_wr}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_bram_wr", {31'd0, bram_wr}, 32'd0);
    checkOutput("abort_ready", {31'd0, bus_ready}, 32'd0);
    checkOutput("abort_error", {31'd0, bus_error}, 32'd0);
    checkOutput("abort_rdata", bus_rdata, 32'd0);
    last_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h14, '0, 4'b0000);

    applyStimulus(1'b1, 32'h40, 32'hDEADBEEF, 4'b1111);
    applyStimulus(1'b0, 32'h40, '0, 4'b0000);
    checkOutput("plan_full_readback", bus_rdata, 32'hDEADBEEF);
    applyStimulus(1'b1, 32'h40, 32'h00000055, 4'b0001);
    applyStimulus(1'b0, 32'h40, '0, 4'b1111);
    checkOutput("plan_byte_readback", bus_rdata, 32'hDEADBE55);
    applyStimulus(1'b1, 32'h40, 32'h12340000, 4'b1100);
    applyStimulus(1'b0, 32'h40, '0, 4'b0101);
    checkOutput("plan_half_readback", bus_rdata, 32'h1234BE55);
    applyStimulus(1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000);
    applyStimulus(1'b0, 32'h40, '0, 4'b0000);
    checkOutput("plan_null_readback", bus_rdata, 32'h1234BE55);

    applyBackToBack();

    applyStimulus(1'b1, 32'h00000400, 32'hCAFEF00D, 4'b1111);
    applyStimulus(1'b0, 32'h00000000, '0, 4'b0000);

    for (int n = 0; n < 60; n++) begin
      addr = $urandom;
      addr[ADDR_SIZE+1:2] = 8'($urandom_range(0, 17));
      if ($urandom_range(0, 7) != 0)
        addr[31:ADDR_SIZE+2] = '0;
      case ($urandom_range(0, 3))
        0:       sel = 4'b1111;
        1:       sel = 4'b0000;
        default: sel = 4'($urandom);
      endcase
      applyStimulus(1'($urandom), addr, $urandom, sel);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
